// File: rtl/pipeline_vector_sched_if.sv
// Handshake and lane bundle shared by the skew scheduler and its upstream/downstream.
interface pipeline_vector_sched_if #(
    parameter int WIDTH = 1,
    parameter int SIZE  = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SIZE*WIDTH-1:0]   in_data;
    logic [SIZE-1:0]         lane_valid;
    logic [SIZE*WIDTH-1:0]   lane_data;
    logic                    word_done;

    modport master (
        output in_valid, in_data,
        input  in_ready, lane_valid, lane_data, word_done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, lane_valid, lane_data, word_done
    );
endinterface

// File: rtl/pipeline_vector_sched.sv
// Skews each accepted word across SIZE lanes so that lane k emerges k ticks after lane 0,
// tracking words in flight and a coarse pipeline state.
module pipeline_vector_sched #(
    parameter int WIDTH = 1,
    parameter int SIZE  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    pipeline_vector_sched_if.slave     bus,
    output logic [$clog2(SIZE+1)-1:0]  occupancy,
    output logic [1:0]                 state
);
    localparam int OCC_W = $clog2(SIZE + 1);
    localparam int NTRI  = SIZE * (SIZE + 1) / 2;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(SIZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STEADY = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [NTRI-1:0]            skew_valid_q, skew_valid_d;
    logic [NTRI-1:0][WIDTH-1:0] skew_data_q, skew_data_d;
    logic                       word_done_q, word_done_d;
    logic [OCC_W-1:0]           occ_q, occ_d;
    logic                       accept;
    logic                       retire;
    logic [SIZE-1:0]            lane_valid_w;
    logic [SIZE*WIDTH-1:0]      lane_data_w;

    assign bus.in_ready = en & ~flush & ~rst;
    assign accept       = bus.in_valid & bus.in_ready;
    // A word stays counted through the tick that shows its word_done, and leaves on the next tick.
    assign retire       = en & word_done_q;

    // Lane k owns a chain of k+1 stages starting at index k*(k+1)/2; the last stage is its output.
    always_comb begin
        skew_valid_d = skew_valid_q;
        skew_data_d  = skew_data_q;
        word_done_d  = word_done_q;
        occ_d        = occ_q;
        state_d      = state_q;
        if (flush) begin
            skew_valid_d = '0;
            skew_data_d  = '0;
            word_done_d  = 1'b0;
            occ_d        = '0;
            state_d      = IDLE;
        end else if (en) begin
            for (int k = 0; k < SIZE; k++) begin
                skew_valid_d[k*(k+1)/2] = accept;
                skew_data_d[k*(k+1)/2]  = accept ? bus.in_data[k*WIDTH +: WIDTH] : '0;
                for (int j = 1; j <= k; j++) begin
                    skew_valid_d[k*(k+1)/2 + j] = skew_valid_q[k*(k+1)/2 + j - 1];
                    skew_data_d[k*(k+1)/2 + j]  = skew_data_q[k*(k+1)/2 + j - 1];
                end
            end
            word_done_d = skew_valid_q[NTRI-2];
            occ_d       = occ_q + OCC_W'(accept) - OCC_W'(retire);
            if (occ_d == '0) begin
                state_d = IDLE;
            end else if (!accept) begin
                state_d = DRAIN;
            end else if (retire) begin
                state_d = STEADY;
            end else begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skew_valid_q <= '0;
            skew_data_q  <= '0;
            word_done_q  <= 1'b0;
            occ_q        <= '0;
            state_q      <= IDLE;
        end else begin
            skew_valid_q <= skew_valid_d;
            skew_data_q  <= skew_data_d;
            word_done_q  <= word_done_d;
            occ_q        <= occ_d;
            state_q      <= state_d;
        end
    end

    always_comb begin
        lane_valid_w = '0;
        lane_data_w  = '0;
        for (int k = 0; k < SIZE; k++) begin
            lane_valid_w[k]              = skew_valid_q[k*(k+1)/2 + k];
            lane_data_w[k*WIDTH +: WIDTH] = skew_data_q[k*(k+1)/2 + k];
        end
    end

    assign bus.lane_valid = lane_valid_w;
    assign bus.lane_data  = lane_data_w;
    assign bus.word_done  = word_done_q;
    assign occupancy      = occ_q;
    assign state          = state_q;

    occupancy_bound: assert property (@(posedge clk) disable iff (rst) occ_q <= OCC_MAX);

endmodule

// File: tb/tb_pipeline_vector_sched.sv
// Directed bench for the lane skew scheduler (SIZE=3, WIDTH=4) with a word scoreboard.
module tb_pipeline_vector_sched;
    localparam int WIDTH = 4;
    localparam int SIZE  = 3;

    typedef struct {
        logic [11:0] data;
        int          t;
    } word_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic [1:0] occupancy;
    logic [1:0] state;

    int    checks;
    int    failures;
    int    tick;
    word_t sb[$];

    pipeline_vector_sched_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

    pipeline_vector_sched #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected lanes come from the words still in the scoreboard and the tick they were accepted on.
    task automatic checkScoreboard(input string tag);
        logic [SIZE-1:0]       ev;
        logic [SIZE*WIDTH-1:0] ed;
        logic                  ewd;
        ev  = '0;
        ed  = '0;
        ewd = 1'b0;
        while (sb.size() > 0 && tick > sb[0].t + SIZE) void'(sb.pop_front());
        foreach (sb[i]) begin
            for (int k = 0; k < SIZE; k++) begin
                if (tick == sb[i].t + 1 + k) begin
                    ev[k]                = 1'b1;
                    ed[k*WIDTH +: WIDTH] = sb[i].data[k*WIDTH +: WIDTH];
                end
            end
            if (tick == sb[i].t + SIZE) ewd = 1'b1;
        end
        checkOutput({tag, "/lane_valid"}, 32'(bus.lane_valid), 32'(ev));
        checkOutput({tag, "/lane_data"}, 32'(bus.lane_data), 32'(ed));
        checkOutput({tag, "/word_done"}, 32'(bus.word_done), 32'(ewd));
        checkOutput({tag, "/occupancy"}, 32'(occupancy), 32'(sb.size()));
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [11:0] d,
                                 input logic e, input logic f, input logic r);
        bus.in_valid = v;
        bus.in_data  = d;
        en           = e;
        flush        = f;
        rst          = r;
        #1;
        checkOutput({tag, "/in_ready"}, 32'(bus.in_ready), 32'(e & ~f & ~r));
        @(posedge clk);
        if (r || f) begin
            sb.delete();
        end else if (e) begin
            if (v) sb.push_back('{data: d, t: tick});
            tick++;
        end
        #1;
        checkScoreboard(tag);
    endtask

    initial begin
        logic [1:0] exp_single[4];
        logic [1:0] exp_stream[9];
        logic [1:0] exp_resume[3];
        checks     = 0;
        failures   = 0;
        tick       = 0;
        exp_single = '{2'd1, 2'd3, 2'd3, 2'd0};
        exp_stream = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        exp_resume = '{2'd3, 2'd3, 2'd0};

        applyStimulus("reset0", 1'b0, 12'h000, 1'b1, 1'b0, 1'b1);
        applyStimulus("reset1", 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b1);
        checkOutput("reset/state", 32'(state), 32'd0);

        // Single word accepted on the very first edge after reset.
        for (int i = 0; i < 4; i++) begin
            applyStimulus("single", i == 0, (i == 0) ? 12'hABC : 12'h000, 1'b1, 1'b0, 1'b0);
            checkOutput("single/state", 32'(state), 32'(exp_single[i]));
        end

        // Six back-to-back words: occupancy saturates at SIZE with accept and retire together.
        for (int i = 0; i < 9; i++) begin
            applyStimulus("stream", i < 6, (i < 6) ? 12'((i + 1) * 12'h111) : 12'h000,
                          1'b1, 1'b0, 1'b0);
            checkOutput("stream/state", 32'(state), 32'(exp_stream[i]));
        end

        applyStimulus("stall_acc", 1'b1, 12'hABC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("stall", 1'b1, 12'h555, 1'b0, 1'b0, 1'b0);
            checkOutput("stall/state", 32'(state), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("resume", 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
            checkOutput("resume/state", 32'(state), 32'(exp_resume[i]));
        end

        applyStimulus("flush_a", 1'b1, 12'h123, 1'b1, 1'b0, 1'b0);
        applyStimulus("flush_b", 1'b1, 12'h456, 1'b1, 1'b0, 1'b0);
        applyStimulus("flush", 1'b1, 12'h789, 1'b1, 1'b1, 1'b0);
        checkOutput("flush/state", 32'(state), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus("post_flush", 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);

        applyStimulus("flush_en0_a", 1'b1, 12'h321, 1'b1, 1'b0, 1'b0);
        applyStimulus("flush_en0", 1'b1, 12'h654, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_en0/state", 32'(state), 32'd0);
        applyStimulus("post_flush_en0", 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);

        applyStimulus("rst_mid_acc", 1'b1, 12'hABC, 1'b1, 1'b0, 1'b0);
        applyStimulus("rst_mid_t1", 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        applyStimulus("rst_mid", 1'b1, 12'hDEF, 1'b1, 1'b1, 1'b1);
        checkOutput("rst_mid/state", 32'(state), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus("post_rst", 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
